melody_player: RTL

MELODY_PLAYER -- requirements
Module: melody_player

---
 rtl/melody_pkg.sv | 59 +++++
 rtl/melody_player_tone_gen.sv | 42 ++++
 rtl/melody_player.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared types, note table, song ROM and half-period helper for the melody player.
package melody_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [3:0] NOTE_END  = 4'hF;
    localparam int         MAX_SONGS = 4;
    localparam int         MAX_LEN   = 16;

    // Ascending semitones from C4; index 2 is D4 and index 4 is E4.
    localparam int FREQ_HZ [16] = '{
        262, 277, 294, 311, 330, 349, 370, 392,
        415, 440, 466, 494, 523, 554, 587, 622
    };

    typedef struct packed {
        logic       rest;
        logic [3:0] note;
    } entry_t;

    typedef entry_t song_t [MAX_LEN];
    typedef song_t  song_rom_t [MAX_SONGS];

    // Entry encoding is {rest, note}; 5'h0F terminates a song.
    localparam song_rom_t SONG_ROM = '{
        '{0: 5'h00, 1: 5'h02, 2: 5'h04, default: 5'h0F},
        '{default: 5'h0F},
        '{0: 5'h09, 1: 5'h10, default: 5'h0F},
        '{5'h00, 5'h02, 5'h04, 5'h05, 5'h07, 5'h09, 5'h0B, 5'h0C,
          5'h0B, 5'h09, 5'h07, 5'h05, 5'h04, 5'h02, 5'h00, 5'h00}
    };

    // Out-of-range positions read as END so the sequencer never runs off the table.
    function automatic entry_t rom_entry(input int song, input int idx);
        entry_t e;
        e = '{rest: 1'b0, note: NOTE_END};
        if (song < MAX_SONGS && idx < MAX_LEN) begin
            e = SONG_ROM[song[1:0]][idx[3:0]];
        end
        return e;
    endfunction

    function automatic logic is_end(input int song, input int idx);
        entry_t e;
        e = rom_entry(song, idx);
        return (e.note == NOTE_END);
    endfunction

    // Clock cycles per half of the square wave; only ever evaluated on constants.
    function automatic int half_period(input int clk_freq, input int note);
        return clk_freq / (2 * FREQ_HZ[note]);
    endfunction

endpackage

// File: rtl/melody_player_tone_gen.sv
// Square-wave generator: toggles every half_period cycles while run is high,
// and restarts low with a cleared counter whenever run drops.
module tone_gen #(
    parameter int HP_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [HP_W-1:0] half_period,
    output logic            tone
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            tone_q, tone_d;

    // Next count/phase: hold in reset phase when idle, toggle at the half-period.
    always_comb begin
        cnt_d  = cnt_q + HP_W'(1);
        tone_d = tone_q;
        if (!run) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == half_period - HP_W'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: steps through a ROM song as timed tones separated by
// silent gaps, with loop, abort, and an idle push-button hold tone.
// Handshake: start/stop are single-cycle requests sampled on the rising edge;
// stop wins over start, and start is only accepted in IDLE or HOLD.
module melody_player
    import melody_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int NOTE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int NUM_SONGS   = 4,
    parameter int SEQ_LEN     = 16,
    parameter int HOLD_NOTE   = 0,
    localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [SONG_W-1:0] song_sel,
    input  logic              hold,
    output logic              audioOut,
    output logic              audioEn,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step,
    output state_e            state_dbg
);

    localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HP_W    = $clog2(CLK_FREQ / (2 * FREQ_HZ[0]) + 1);

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef logic [15:0][HP_W-1:0] hp_tab_t;

    function automatic hp_tab_t build_hp_tab();
        hp_tab_t t;
        for (int n = 0; n < 16; n++) begin
            t[n] = HP_W'(half_period(CLK_FREQ, n));
        end
        return t;
    endfunction

    // Half-periods are constants; a runtime lookup is just a mux.
    localparam hp_tab_t HP_TAB = build_hp_tab();

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    entry_t              cur_e;
    logic [STEP_W:0]     nxt_idx;
    logic                nxt_end, first_end, seq_end, start_ok;
    logic                sounding, run, tone;
    logic [3:0]          play_note;
    logic [HP_W-1:0]     hp_sel;

    assign cur_e     = rom_entry(int'(song_q), int'(step_q));
    assign nxt_idx   = {1'b0, step_q} + (STEP_W + 1)'(1);
    assign nxt_end   = is_end(int'(song_q), int'(nxt_idx));
    assign first_end = is_end(int'(song_sel), 0);
    assign seq_end   = (nxt_idx == (STEP_W + 1)'(SEQ_LEN)) || nxt_end;
    assign start_ok  = start && !stop;

    // Next-state logic for the sequencer and its step/duration counters.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        song_d  = song_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start_ok) begin
                    song_d = song_sel;
                    step_d = '0;
                    cnt_d  = '0;
                    if (first_end) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_TONE;
                    end
                end else if (state_q == ST_IDLE && hold) begin
                    state_d = ST_HOLD;
                end else if (state_q == ST_HOLD && !hold) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == NOTE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (seq_end) begin
                        step_d = '0;
                        if (loop) begin
                            state_d = ST_TONE;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d  = nxt_idx[STEP_W-1:0];
                        state_d = ST_TONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset silences and parks the block in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            song_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            song_q  <= song_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // The tone generator is held in its reset phase on any state change, so a
    // new note (including HOLD pre-empted by start) always begins low.
    assign sounding  = (state_q == ST_HOLD) || (state_q == ST_TONE && !cur_e.rest);
    assign run       = sounding && (state_d == state_q);
    assign play_note = (state_q == ST_HOLD) ? 4'(HOLD_NOTE) : cur_e.note;
    assign hp_sel    = HP_TAB[play_note];

    tone_gen #(
        .HP_W (HP_W)
    ) u_tone_gen (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .half_period (hp_sel),
        .tone        (tone)
    );

    assign audioOut  = tone && sounding;
    assign audioEn   = (state_q != ST_IDLE);
    assign busy      = (state_q == ST_TONE) || (state_q == ST_GAP);
    assign done      = done_q;
    assign step      = step_q;
    assign state_dbg = state_q;

endmodule
